// File: rtl/texture_sampler.sv
// Texture sampler: accepts one ray-column texel request, derives the texel row with a
// 16-step restoring divider, reads the texture BROM and returns the texel with a one-cycle pulse.
module texture_sampler #(
  parameter int    TEX_WIDTH   = 64,
  parameter int    TEX_HEIGHT  = 64,
  parameter int    TEX_BASE_ID = 3,
  parameter int    NUM_TEX     = 3,
  parameter int    ROM_LATENCY = 2,
  parameter string INIT_FILE   = "textures.mem"
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic        valid_req_in,
  input  logic [15:0] wallX_in,
  input  logic [7:0]  lineheight_in,
  input  logic [9:0]  drawstart_in,
  input  logic [9:0]  vcount_ray_in,
  input  logic [3:0]  texture_in,
  output logic [15:0] tex_pixel_out,
  output logic        valid_tex_out
);

  localparam int TX_W      = $clog2(TEX_WIDTH);
  localparam int TY_W      = $clog2(TEX_HEIGHT);
  localparam int DEPTH     = NUM_TEX * TEX_WIDTH * TEX_HEIGHT;
  localparam int ADDR_W    = $clog2(DEPTH);
  localparam int DIV_STEPS = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_DIVIDE, S_ADDR, S_ROM_WAIT, S_RESPOND, S_COOLDOWN
  } state_t;

  state_t state, state_nxt;
  logic [4:0] cnt, cnt_nxt;

  logic [TX_W-1:0]   tex_x_p0;
  logic [3:0]        tex_id_p0;
  logic [15:0]       dvd_p0;
  logic [7:0]        dvs_p0;
  logic [7:0]        rem_p0;
  logic [15:0]       quo_p0;
  logic [ADDR_W-1:0] addr_p1;
  logic              id_ok_p1;
  logic [15:0]       rom_p [ROM_LATENCY];
  logic [15:0]       rom_rd;

  function automatic logic [10:0] sat_nonneg(input logic signed [10:0] v);
    return v[10] ? 11'd0 : $unsigned(v);
  endfunction

  function automatic logic [TY_W-1:0] sat_tex_y(input logic [15:0] q);
    return (q > 16'(TEX_HEIGHT - 1)) ? TY_W'(TEX_HEIGHT - 1) : q[TY_W-1:0];
  endfunction

  // Acceptance stage: row offset below the wall top, scaled to texture rows
  logic signed [10:0] row_diff;
  logic [10:0]        row_off;
  logic [15:0]        dividend;
  assign row_diff = $signed({vcount_ray_in[9], vcount_ray_in}) - $signed({drawstart_in[9], drawstart_in});
  assign row_off  = sat_nonneg(row_diff);
  assign dividend = 16'({5'd0, row_off} << TY_W);

  // Divider step: the 9-bit partial remainder is shift-in of the next dividend bit
  logic [8:0] rem_sh;
  logic       q_bit;
  assign rem_sh = {rem_p0, dvd_p0[15]};
  assign q_bit  = (dvs_p0 != 8'd0) && (rem_sh >= {1'b0, dvs_p0});

  // Address stage: unknown ids read texture 0 but are replaced by magenta at the output
  logic              id_ok;
  logic [3:0]        tex_idx;
  logic [ADDR_W-1:0] rom_addr;
  assign id_ok    = (int'(tex_id_p0) >= TEX_BASE_ID) && (int'(tex_id_p0) < TEX_BASE_ID + NUM_TEX);
  assign tex_idx  = id_ok ? (tex_id_p0 - 4'(TEX_BASE_ID)) : 4'd0;
  assign rom_addr = (ADDR_W'(tex_idx) << (TY_W + TX_W))
                  | (ADDR_W'(sat_tex_y(quo_p0)) << TX_W)
                  | ADDR_W'(tex_x_p0);

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= S_IDLE;
      cnt   <= 5'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      S_IDLE: begin
        if (valid_req_in) begin
          state_nxt = S_DIVIDE;
          cnt_nxt   = 5'd0;
        end
      end
      S_DIVIDE: begin
        if (cnt == 5'(DIV_STEPS - 1)) begin
          state_nxt = S_ADDR;
          cnt_nxt   = 5'd0;
        end else begin
          cnt_nxt = cnt + 5'd1;
        end
      end
      S_ADDR: begin
        state_nxt = S_ROM_WAIT;
        cnt_nxt   = 5'd0;
      end
      S_ROM_WAIT: begin
        if (cnt == 5'(ROM_LATENCY - 1)) state_nxt = S_RESPOND;
        else                            cnt_nxt   = cnt + 5'd1;
      end
      S_RESPOND:  state_nxt = S_COOLDOWN;
      S_COOLDOWN: if (!valid_req_in) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Latch / divide / address registers; all cleared so a reset fully drops the request
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      tex_x_p0  <= '0;
      tex_id_p0 <= '0;
      dvd_p0    <= '0;
      dvs_p0    <= '0;
      rem_p0    <= '0;
      quo_p0    <= '0;
      addr_p1   <= '0;
      id_ok_p1  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (valid_req_in) begin
            tex_x_p0  <= wallX_in[15 -: TX_W];
            tex_id_p0 <= texture_in;
            dvd_p0    <= dividend;
            dvs_p0    <= lineheight_in;
            rem_p0    <= '0;
            quo_p0    <= '0;
          end
        end
        S_DIVIDE: begin
          dvd_p0 <= {dvd_p0[14:0], 1'b0};
          rem_p0 <= q_bit ? 8'(rem_sh - {1'b0, dvs_p0}) : rem_sh[7:0];
          quo_p0 <= {quo_p0[14:0], q_bit};
        end
        S_ADDR: begin
          addr_p1  <= rom_addr;
          id_ok_p1 <= id_ok;
        end
        default: ;
      endcase
    end
  end

  // BROM read pipeline, ROM_LATENCY cycles from the registered address
  if (INIT_FILE == "") begin : g_pattern
    assign rom_rd = 16'(addr_p1);
  end else begin : g_image
    logic [15:0] rom_mem [DEPTH];
    initial begin
      for (int i = 0; i < DEPTH; i++) rom_mem[i] = 16'(i);
    end
    assign rom_rd = rom_mem[addr_p1];
  end

  always_ff @(posedge pixel_clk_in) begin
    rom_p[0] <= rom_rd;
    for (int i = 1; i < ROM_LATENCY; i++) rom_p[i] <= rom_p[i-1];
  end

  // Output stage
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_tex_out <= 1'b0;
      tex_pixel_out <= 16'h0000;
    end else begin
      valid_tex_out <= (state == S_RESPOND);
      if (state == S_RESPOND) tex_pixel_out <= id_ok_p1 ? rom_p[ROM_LATENCY-1] : 16'hF81F;
    end
  end

endmodule

// File: tb/tb_texture_sampler.sv
// Bench for texture_sampler: directed scenarios plus randomized requests checked
// against an arithmetic model of the texel address (identity texture image).
module tb_texture_sampler;

  localparam int TW = 64;
  localparam int TH = 64;

  logic        pixel_clk_in = 1'b0;
  logic        rst_in;
  logic        valid_req_in;
  logic [15:0] wallX_in;
  logic [7:0]  lineheight_in;
  logic [9:0]  drawstart_in;
  logic [9:0]  vcount_ray_in;
  logic [3:0]  texture_in;
  logic [15:0] tex_pixel_out;
  logic        valid_tex_out;

  int checks = 0;
  int errors = 0;

  always #5 pixel_clk_in = ~pixel_clk_in;

  texture_sampler #(.INIT_FILE("")) dut (
    .pixel_clk_in (pixel_clk_in),
    .rst_in       (rst_in),
    .valid_req_in (valid_req_in),
    .wallX_in     (wallX_in),
    .lineheight_in(lineheight_in),
    .drawstart_in (drawstart_in),
    .vcount_ray_in(vcount_ray_in),
    .texture_in   (texture_in),
    .tex_pixel_out(tex_pixel_out),
    .valid_tex_out(valid_tex_out)
  );

  // Reference: texel word equals its address in the identity image
  function automatic logic [15:0] ref_pixel(input logic [3:0] tex, input logic [15:0] wx,
                                            input logic [7:0] lh, input logic [9:0] ds,
                                            input logic [9:0] vc);
    int tx, vci, dsi, d, dv, q, ty;
    tx  = (int'(wx) * TW) / 65536;
    vci = (vc >= 10'd512) ? int'(vc) - 1024 : int'(vc);
    dsi = (ds >= 10'd512) ? int'(ds) - 1024 : int'(ds);
    d   = vci - dsi;
    if (d < 0) d = 0;
    dv  = (d * TH) % 65536;
    q   = (lh == 8'd0) ? 0 : dv / int'(lh);
    ty  = (q > TH - 1) ? TH - 1 : q;
    if (tex < 4'd3 || tex > 4'd5) return 16'hF81F;
    return 16'(((int'(tex) - 3) * TH + ty) * TW + tx);
  endfunction

  // Issues one request, measures pulse latency (cycles after the acceptance cycle),
  // pulse count and texel. Inputs are scrambled right after acceptance.
  task automatic do_req(input logic [3:0] tex, input logic [15:0] wx, input logic [7:0] lh,
                        input logic [9:0] ds, input logic [9:0] vc, input int hold_extra,
                        input int early_drop, input int tail,
                        output int lat, output int npulse, output logic [15:0] pix);
    int stop_at;
    @(negedge pixel_clk_in);
    texture_in = tex; wallX_in = wx; lineheight_in = lh;
    drawstart_in = ds; vcount_ray_in = vc; valid_req_in = 1'b1;
    lat = -1; npulse = 0; pix = 'x; stop_at = 60;
    for (int j = 1; j <= stop_at; j++) begin
      @(negedge pixel_clk_in);
      if (j == 1) begin
        texture_in = 4'($urandom); wallX_in = 16'($urandom); lineheight_in = 8'($urandom);
        drawstart_in = 10'($urandom); vcount_ray_in = 10'($urandom);
      end
      if (j == early_drop) valid_req_in = 1'b0;
      if (valid_tex_out === 1'b1) begin
        npulse++;
        if (lat < 0) begin
          lat = j; pix = tex_pixel_out; stop_at = j + hold_extra + tail;
        end
      end
      if (lat > 0 && j == lat + hold_extra) valid_req_in = 1'b0;
    end
    valid_req_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; valid_req_in = 1'b0; wallX_in = '0; lineheight_in = '0;
    drawstart_in = '0; vcount_ray_in = '0; texture_in = '0;
    repeat (3) @(negedge pixel_clk_in);
    checks++; if (valid_tex_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", valid_tex_out); end
    checks++; if (tex_pixel_out !== 16'h0) begin errors++; $display("FAIL reset_pixel: got %h, expected 0000", tex_pixel_out); end
    rst_in = 1'b0;
    repeat (2) @(negedge pixel_clk_in);
    checks++; if (valid_tex_out !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b, expected 0", valid_tex_out); end
  endtask

  task automatic test_basic();
    int lat, np; logic [15:0] pix;
    do_req(4'd3, 16'h8000, 8'd64, 10'd58, 10'd90, 1, 0, 4, lat, np, pix);
    checks++; if (lat !== 21) begin errors++; $display("FAIL basic_latency: got %0d, expected 21", lat); end
    checks++; if (pix !== 16'h0820) begin errors++; $display("FAIL basic_pixel: got %h, expected 0820", pix); end
    checks++; if (np !== 1) begin errors++; $display("FAIL basic_pulses: got %0d, expected 1", np); end
  endtask

  task automatic test_clamp();
    int lat, np; logic [15:0] pix;
    do_req(4'd5, 16'h0000, 8'd10, 10'd85, 10'd95, 1, 0, 2, lat, np, pix);
    checks++; if (lat !== 21) begin errors++; $display("FAIL clamp_latency: got %0d, expected 21", lat); end
    checks++; if (pix !== 16'h2FC0) begin errors++; $display("FAIL clamp_pixel: got %h, expected 2fc0", pix); end
  endtask

  task automatic test_neg_drawstart();
    int lat, np; logic [15:0] pix;
    do_req(4'd4, 16'hFFFF, 8'd254, 10'h3DB, 10'd0, 1, 0, 2, lat, np, pix);
    checks++; if (lat !== 21) begin errors++; $display("FAIL negds_latency: got %0d, expected 21", lat); end
    checks++; if (pix !== 16'd4735) begin errors++; $display("FAIL negds_pixel: got %0d, expected 4735", pix); end
  endtask

  task automatic test_degenerate();
    int lat, np; logic [15:0] pix;
    do_req(4'd3, 16'h8000, 8'd0, 10'd58, 10'd90, 1, 0, 2, lat, np, pix);
    checks++; if (lat !== 21) begin errors++; $display("FAIL lh0_latency: got %0d, expected 21", lat); end
    checks++; if (pix !== 16'h0020) begin errors++; $display("FAIL lh0_pixel: got %h, expected 0020", pix); end
    do_req(4'd1, 16'h8000, 8'd64, 10'd58, 10'd90, 1, 0, 2, lat, np, pix);
    checks++; if (lat !== 21) begin errors++; $display("FAIL badid_latency: got %0d, expected 21", lat); end
    checks++; if (pix !== 16'hF81F) begin errors++; $display("FAIL badid_pixel: got %h, expected f81f", pix); end
  endtask

  task automatic test_handshake();
    int lat, np; logic [15:0] pix;
    do_req(4'd4, 16'h4000, 8'd100, 10'd20, 10'd70, 7, 0, 6, lat, np, pix);
    checks++; if (np !== 1) begin errors++; $display("FAIL hold_pulses: got %0d, expected 1", np); end
    do_req(4'd3, 16'h1234, 8'd40, 10'd5, 10'd30, 1, 0, 0, lat, np, pix);
    do_req(4'd5, 16'hC000, 8'd80, 10'd10, 10'd50, 1, 0, 2, lat, np, pix);
    checks++; if (lat !== 21) begin errors++; $display("FAIL rereq_latency: got %0d, expected 21", lat); end
    checks++; if (pix !== ref_pixel(4'd5, 16'hC000, 8'd80, 10'd10, 10'd50)) begin errors++; $display("FAIL rereq_pixel: got %h, expected %h", pix, ref_pixel(4'd5, 16'hC000, 8'd80, 10'd10, 10'd50)); end
    do_req(4'd4, 16'h2000, 8'd30, 10'd0, 10'd15, 1, 3, 2, lat, np, pix);
    checks++; if (lat !== 21) begin errors++; $display("FAIL drop_latency: got %0d, expected 21", lat); end
    checks++; if (pix !== ref_pixel(4'd4, 16'h2000, 8'd30, 10'd0, 10'd15)) begin errors++; $display("FAIL drop_pixel: got %h, expected %h", pix, ref_pixel(4'd4, 16'h2000, 8'd30, 10'd0, 10'd15)); end
  endtask

  task automatic test_random();
    int lat, np; logic [15:0] pix, exp_pix;
    logic [3:0] tex; logic [15:0] wx; logic [7:0] lh; logic [9:0] ds, vc;
    for (int k = 0; k < 30; k++) begin
      tex = 4'($urandom_range(0, 7)); wx = 16'($urandom); lh = 8'($urandom_range(0, 255));
      ds = 10'($urandom); vc = 10'($urandom_range(0, 179));
      exp_pix = ref_pixel(tex, wx, lh, ds, vc);
      do_req(tex, wx, lh, ds, vc, 1, 0, 1, lat, np, pix);
      checks++; if (lat !== 21 || np !== 1) begin errors++; $display("FAIL rand_timing[%0d]: latency %0d pulses %0d, expected 21 and 1", k, lat, np); end
      checks++; if (pix !== exp_pix) begin errors++; $display("FAIL rand_pixel[%0d]: got %h, expected %h", k, pix, exp_pix); end
    end
  endtask

  task automatic test_back_to_back();
    int lat, np, total; logic [15:0] pix, exp_pix;
    logic [3:0] tex; logic [15:0] wx; logic [7:0] lh; logic [9:0] ds;
    tex = 4'($urandom_range(3, 5)); wx = 16'($urandom);
    lh = 8'($urandom_range(1, 255)); ds = 10'($urandom_range(0, 179));
    total = 0;
    for (int row = 0; row < 180; row++) begin
      exp_pix = ref_pixel(tex, wx, lh, ds, 10'(row));
      do_req(tex, wx, lh, ds, 10'(row), 1, 0, 0, lat, np, pix);
      total += np;
      checks++; if (pix !== exp_pix || lat !== 21) begin errors++; $display("FAIL b2b_row[%0d]: got %h at %0d, expected %h at 21", row, pix, lat, exp_pix); end
    end
    checks++; if (total !== 180) begin errors++; $display("FAIL b2b_pulses: got %0d, expected 180", total); end
  endtask

  task automatic test_reset_mid();
    int lat, np, late; logic [15:0] pix;
    do_req(4'd3, 16'h8000, 8'd64, 10'd58, 10'd90, 1, 0, 2, lat, np, pix);
    @(negedge pixel_clk_in);
    texture_in = 4'd3; wallX_in = 16'h8000; lineheight_in = 8'd64;
    drawstart_in = 10'd58; vcount_ray_in = 10'd90; valid_req_in = 1'b1;
    repeat (8) @(posedge pixel_clk_in);
    #2;
    rst_in = 1'b1; valid_req_in = 1'b0;
    #1;
    checks++; if (valid_tex_out !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b, expected 0", valid_tex_out); end
    checks++; if (tex_pixel_out !== 16'h0) begin errors++; $display("FAIL midrst_pixel: got %h, expected 0000", tex_pixel_out); end
    @(negedge pixel_clk_in);
    rst_in = 1'b0;
    late = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge pixel_clk_in);
      if (valid_tex_out === 1'b1) late++;
    end
    checks++; if (late !== 0) begin errors++; $display("FAIL midrst_no_pulse: got %0d pulses, expected 0", late); end
    do_req(4'd3, 16'h8000, 8'd64, 10'd58, 10'd90, 1, 0, 2, lat, np, pix);
    checks++; if (lat !== 21) begin errors++; $display("FAIL after_rst_latency: got %0d, expected 21", lat); end
    checks++; if (pix !== 16'h0820) begin errors++; $display("FAIL after_rst_pixel: got %h, expected 0820", pix); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_neg_drawstart();
    test_degenerate();
    test_handshake();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
